// File: rtl/count_frame_packetizer.sv
// count_frame_packetizer: latches three 32-bit counts on snap and streams a 15-byte checksummed frame over a start/done byte handshake
module count_frame_packetizer #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snap,
  input  logic [31:0] count_a,
  input  logic [31:0] count_b,
  input  logic [31:0] count_ab,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  drop_cnt
);
  typedef enum logic [2:0] {IDLE, START, WAIT, GAP, FIN} state_t;
  state_t stateQ, stateNext;
  logic [31:0] capA, capB, capAb;
  logic [7:0] capSeq, capSum, seq, snapSum, nextByte;
  logic [3:0] idx, idxNext;
  logic [15:0] gapCnt;
  logic txDoneQ, doneEdge;
  assign doneEdge = tx_done & ~txDoneQ;
  // checksum of bytes 1..13 formed from the live inputs so it can be latched with them
  always_comb
    snapSum = seq + count_a[31:24] + count_a[23:16] + count_a[15:8] + count_a[7:0]
            + count_b[31:24] + count_b[23:16] + count_b[15:8] + count_b[7:0]
            + count_ab[31:24] + count_ab[23:16] + count_ab[15:8] + count_ab[7:0];
  // next-state and byte index; IDLE->START keeps idx 0, whose byte needs no captured data
  always_comb begin
    stateNext = stateQ;
    idxNext = idx;
    case (stateQ)
      IDLE: if (snap) begin
        stateNext = START;
        idxNext = 4'd0;
      end
      START: stateNext = WAIT;
      WAIT: if (doneEdge) begin
        if (idx == 4'd14) stateNext = FIN;
        else begin
          idxNext = idx + 4'd1;
          stateNext = (GAP_CYCLES > 0) ? GAP : START;
        end
      end
      GAP: stateNext = (gapCnt == 16'(GAP_CYCLES - 1)) ? START : GAP;
      FIN: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end
  // frame byte selected by the index the next START will use
  always_comb begin
    nextByte = 8'h00;
    case (idxNext)
      4'd0: nextByte = SYNC_BYTE;
      4'd1: nextByte = capSeq;
      4'd2: nextByte = capA[31:24];
      4'd3: nextByte = capA[23:16];
      4'd4: nextByte = capA[15:8];
      4'd5: nextByte = capA[7:0];
      4'd6: nextByte = capB[31:24];
      4'd7: nextByte = capB[23:16];
      4'd8: nextByte = capB[15:8];
      4'd9: nextByte = capB[7:0];
      4'd10: nextByte = capAb[31:24];
      4'd11: nextByte = capAb[23:16];
      4'd12: nextByte = capAb[15:8];
      4'd13: nextByte = capAb[7:0];
      4'd14: nextByte = capSum;
      default: nextByte = 8'h00;
    endcase
  end
  // state, index, done-edge history and gap timer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stateQ <= IDLE;
      idx <= 4'd0;
      txDoneQ <= 1'b0;
      gapCnt <= 16'd0;
    end else begin
      stateQ <= stateNext;
      idx <= idxNext;
      txDoneQ <= tx_done;
      gapCnt <= (stateQ == GAP) ? gapCnt + 16'd1 : 16'd0;
    end
  // registered outputs follow the state being entered so they line up with it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_start <= 1'b0;
      tx_data <= 8'h00;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_start <= stateNext == START;
      busy <= stateNext != IDLE;
      frame_done <= stateNext == FIN;
      if (stateNext == START) tx_data <= nextByte;
    end
  // capture on accepted snap, sequence advance on frame end, saturating drop counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      capA <= 32'd0;
      capB <= 32'd0;
      capAb <= 32'd0;
      capSeq <= 8'd0;
      capSum <= 8'd0;
      seq <= 8'd0;
      drop_cnt <= 8'd0;
    end else begin
      if (stateQ == IDLE && snap) begin
        capA <= count_a;
        capB <= count_b;
        capAb <= count_ab;
        capSeq <= seq;
        capSum <= snapSum;
      end
      if (stateQ == FIN) seq <= seq + 8'd1;
      if (stateQ != IDLE && snap && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
endmodule
